bpc_code_unbuf: RTL



---
 rtl/bpc_code_unbuf.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bpc_code_unbuf.sv
// Bit-stream unpacker for the BPC decoder: packs 64-bit code words into a bit buffer and
// presents an MSB-aligned window from which the decoder consumes a variable number of bits.
module bpc_code_unbuf #(
  parameter int DW   = 64,
  parameter int WIN  = 152,
  parameter int BUFW = 256,
  parameter int SZW  = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           blk_valid_i,
  input  logic [SZW-1:0] blk_size_i,
  output logic           blk_ready_o,
  input  logic [DW-1:0]  data_i,
  input  logic           d_valid_i,
  output logic           d_ready_o,
  output logic [WIN-1:0] win_o,
  output logic [7:0]     win_bits_o,
  output logic           win_valid_o,
  input  logic           consume_i,
  input  logic [7:0]     consume_size_i,
  output logic           done_o,
  output logic           err_o
);

  localparam int CW  = $clog2(BUFW + 1);
  localparam int XW  = ((SZW > CW) ? SZW : CW) + 2;
  localparam int DSH = $clog2(DW);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t          state, state_n;
  logic [BUFW-1:0] buf_q, buf_n, buf_shl, buf_ins;
  logic [XW-1:0]   buf_cnt, cnt_n, remaining, rem_n, word_left, wl_n;
  logic [XW-1:0]   size_x, wbits_x, cons_x, resid_x, wb_n;
  logic            err_n, wv_n, load, over_cons;

  function automatic logic [XW-1:0] umin(input logic [XW-1:0] a, input logic [XW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Consume is clamped to what the window legally offers, so buf_cnt/remaining never underflow.
  always_comb begin
    size_x    = XW'(consume_size_i);
    wbits_x   = XW'(win_bits_o);
    over_cons = (state == ACTIVE) && consume_i && (!win_valid_o || (size_x > wbits_x));
    cons_x    = '0;
    if ((state == ACTIVE) && consume_i && win_valid_o)
      cons_x = umin(size_x, wbits_x);
    resid_x   = buf_cnt - cons_x;
    d_ready_o = (state == ACTIVE) && (word_left != '0) && (resid_x <= XW'(BUFW - DW));
    load      = d_ready_o && d_valid_i;
    buf_shl   = buf_q << cons_x;
    // New word lands directly behind the residual bits left after this cycle's consume.
    buf_ins   = {data_i, {(BUFW-DW){1'b0}}} >> resid_x;
  end

  always_comb begin
    state_n = state;
    buf_n   = buf_q;
    cnt_n   = buf_cnt;
    rem_n   = remaining;
    wl_n    = word_left;
    err_n   = err_o;
    case (state)
      IDLE: begin
        if (blk_valid_i) begin
          rem_n   = XW'(blk_size_i);
          wl_n    = (XW'(blk_size_i) + XW'(DW - 1)) >> DSH;
          err_n   = 1'b0;
          state_n = (blk_size_i == '0) ? DONE : ACTIVE;
        end
      end
      ACTIVE: begin
        buf_n = load ? (buf_shl | buf_ins) : buf_shl;
        cnt_n = resid_x + (load ? XW'(DW) : XW'(0));
        rem_n = remaining - cons_x;
        if (load)      wl_n  = word_left - XW'(1);
        if (over_cons) err_n = 1'b1;
        if (rem_n == '0) state_n = DONE;
      end
      DONE: begin
        buf_n   = '0;
        cnt_n   = '0;
        wl_n    = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    wb_n = '0;
    wv_n = 1'b0;
    if (state_n == ACTIVE) begin
      wb_n = umin(umin(cnt_n, rem_n), XW'(WIN));
      wv_n = (rem_n != '0) && (wb_n == umin(rem_n, XW'(WIN)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      buf_q       <= '0;
      buf_cnt     <= '0;
      remaining   <= '0;
      word_left   <= '0;
      win_bits_o  <= '0;
      win_valid_o <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state       <= state_n;
      buf_q       <= buf_n;
      buf_cnt     <= cnt_n;
      remaining   <= rem_n;
      word_left   <= wl_n;
      win_bits_o  <= wb_n[7:0];
      win_valid_o <= wv_n;
      done_o      <= (state_n == DONE);
      err_o       <= err_n;
    end
  end

  assign win_o       = buf_q[BUFW-1 -: WIN];
  assign blk_ready_o = (state == IDLE);

endmodule
